// File: rtl/delay_lines_pkg.sv
// delay_lines_pkg: shared state encoding and width helper
// for the delay_lines line buffer.
package delay_lines_pkg;

    typedef enum logic [1:0] {
        CFG  = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    function automatic int col_width(input int img_width,
                                     input int channel_nb);
        return img_width * channel_nb;
    endfunction

endpackage

// File: rtl/delay_lines_line_ram.sv
// line_ram: simple dual-port synchronous RAM, read-before-write.
// Only the read register is reset; the array keeps its contents.
module line_ram #(
    parameter int WIDTH  = 8,
    parameter int AWIDTH = 16,
    parameter int DEPTH  = 1 << AWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [AWIDTH-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/delay_lines.sv
// delay_lines: multi-channel line-delay buffer with valid/ready handshake.
// Define DELAY_LINES_FRAME_EN to add the up_eof frame-restart input.
module delay_lines
    import delay_lines_pkg::*;
#(
    parameter int HEIGHT_NB  = 3,
    parameter int IMG_WIDTH  = 8,
    parameter int CHANNEL_NB = 1,
    parameter int MEM_AWIDTH = 16,
    parameter int MEM_DEPTH  = 1 << MEM_AWIDTH
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [MEM_AWIDTH-1:0]                     cfg_delay,
    input  logic                                      cfg_set,
    input  logic [IMG_WIDTH*CHANNEL_NB-1:0]           up_data,
    input  logic                                      up_val,
`ifdef DELAY_LINES_FRAME_EN
    input  logic                                      up_eof,
`endif
    output logic                                      up_rdy,
    output logic [IMG_WIDTH*CHANNEL_NB*HEIGHT_NB-1:0] dn_data,
    output logic                                      dn_val,
    input  logic                                      dn_rdy
);

    localparam int CW = col_width(IMG_WIDTH, CHANNEL_NB);
    localparam int NL = HEIGHT_NB - 1;
    localparam int LW = $clog2(HEIGHT_NB);

    state_t                state, state_nx;
    logic [MEM_AWIDTH-1:0] col, col_nx, len;
    logic [MEM_AWIDTH-1:0] col_q;
    logic [LW-1:0]         line_cnt, line_cnt_nx;
    logic                  acc, acc_q, eof, wrap;
    logic                  dn_val_nx, byp;
    logic [CW-1:0]         data_q;
    logic [CW-1:0]         ram_q [NL];
    logic [CW-1:0]         byp_q [NL];
    logic [CW-1:0]         slice [HEIGHT_NB];

`ifdef DELAY_LINES_FRAME_EN
    assign eof = up_eof;
`else
    assign eof = 1'b0;
`endif

    assign up_rdy = (state != CFG) & ~cfg_set & (~dn_val | dn_rdy);
    assign acc    = up_val & up_rdy;
    assign wrap   = (col == len - 1'b1);

    always_comb begin
        state_nx    = state;
        col_nx      = col;
        line_cnt_nx = line_cnt;
        dn_val_nx   = dn_val;
        if (cfg_set) begin
            state_nx    = (cfg_delay == '0) ? CFG : FILL;
            col_nx      = '0;
            line_cnt_nx = '0;
            dn_val_nx   = 1'b0;
        end else if (acc) begin
            col_nx    = wrap ? '0 : col + 1'b1;
            dn_val_nx = (state == RUN);
            if (state == FILL && wrap) begin
                if (line_cnt == LW'(HEIGHT_NB - 2)) state_nx = RUN;
                else line_cnt_nx = line_cnt + 1'b1;
            end
            if (eof) begin
                state_nx    = FILL;
                col_nx      = '0;
                line_cnt_nx = '0;
            end
        end else if (dn_rdy) begin
            dn_val_nx = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CFG;
            col      <= '0;
            line_cnt <= '0;
            len      <= '0;
            dn_val   <= 1'b0;
        end else begin
            state    <= state_nx;
            col      <= col_nx;
            line_cnt <= line_cnt_nx;
            dn_val   <= dn_val_nx;
            if (cfg_set) len <= cfg_delay;
        end
    end

    // Lines are rewritten one cycle after acceptance from the output
    // column itself; a read hitting that pending write is bypassed.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= 1'b0;
            col_q  <= '0;
            data_q <= '0;
            byp    <= 1'b0;
            for (int h = 0; h < NL; h++) byp_q[h] <= '0;
        end else begin
            acc_q <= acc;
            if (acc) begin
                col_q  <= col;
                data_q <= up_data;
                byp    <= acc_q & (col_q == col);
                for (int h = 0; h < NL; h++) byp_q[h] <= slice[h];
            end
        end
    end

    always_comb begin
        slice[0] = data_q;
        for (int h = 0; h < NL; h++)
            slice[h+1] = byp ? byp_q[h] : ram_q[h];
    end

    always_comb begin
        dn_data = '0;
        for (int h = 0; h < HEIGHT_NB; h++)
            dn_data[h*CW +: CW] = slice[h];
    end

    for (genvar g = 0; g < NL; g++) begin : g_line
        line_ram #(
            .WIDTH  (CW),
            .AWIDTH (MEM_AWIDTH),
            .DEPTH  (MEM_DEPTH)
        ) u_ram (
            .clk   (clk),
            .rst   (rst),
            .we    (acc_q),
            .waddr (col_q),
            .wdata (slice[g]),
            .re    (acc),
            .raddr (col),
            .rdata (ram_q[g])
        );
    end

endmodule
